// File: rtl/audio_path_ctrl.sv
// audio_path_ctrl: sequences the 1-bit mic -> FIFO -> amplifier loopback path.
// Generates the mic bit clock, fills an external FIFO to a prefill level,
// streams samples to the amp PWM pin, and drains the FIFO on stop.
module audio_path_ctrl #(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned PREFILL = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_mic_data,
  output logic             o_mclk,
  output logic             o_fifo_din,
  output logic             o_fifo_wr,
  output logic             o_fifo_rd,
  input  logic             i_fifo_dout,
  input  logic             i_fifo_full,
  input  logic             i_fifo_empty,
  input  logic [FIFO_AW:0] i_fifo_level,
  output logic             o_amp_pwm,
  output logic             o_amp_sd,
  output logic [1:0]       o_state,
  output logic [7:0]       o_overrun_cnt,
  output logic [7:0]       o_underrun_cnt
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LVL_W = FIFO_AW + 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [LVL_W-1:0] PREFILL_LVL = LVL_W'(PREFILL);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;

  logic [DIV_W-1:0] r_div;
  logic             r_mclk;
  logic             w_div_term;
  logic             w_tick;

  logic             r_fifo_wr;
  logic             r_fifo_rd;
  logic             r_fifo_din;
  logic             r_rd_dly;
  logic             r_amp_pwm;
  logic             r_amp_sd;
  logic [CNT_W-1:0] r_overrun_cnt;
  logic [CNT_W-1:0] r_underrun_cnt;

  logic             w_wr_nxt;
  logic             w_rd_nxt;
  logic             w_din_nxt;
  logic             w_ovr_inc;
  logic             w_und_inc;

  // tick marks the cycle whose closing edge raises mclk
  assign w_div_term = (r_div == DIV_LAST);
  assign w_tick     = w_div_term & ~r_mclk;

  // Free-running mic clock divider, active in every state
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_div  <= '0;
      r_mclk <= 1'b0;
    end else if (w_div_term) begin
      r_div  <= '0;
      r_mclk <= ~r_mclk;
    end else begin
      r_div  <= r_div + DIV_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-tick FIFO decisions, all from pre-tick flags
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_din_nxt   = r_fifo_din;
    w_ovr_inc   = 1'b0;
    w_und_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_tick) begin
          if (i_fifo_full) begin
            w_ovr_inc = 1'b1;
          end else begin
            w_wr_nxt  = 1'b1;
            w_din_nxt = i_mic_data;
          end
        end
        if (!i_enable) begin
          w_state_nxt = S_DRAIN;
        end else if (i_fifo_level >= PREFILL_LVL) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_tick) begin
          if (i_fifo_full) begin
            w_ovr_inc = 1'b1;
          end else begin
            w_wr_nxt  = 1'b1;
            w_din_nxt = i_mic_data;
          end
          if (i_fifo_empty) begin
            w_und_inc = 1'b1;
          end else begin
            w_rd_nxt  = 1'b1;
          end
        end
        if (!i_enable) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_tick) begin
          if (i_fifo_empty) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_rd_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FIFO strobes and write data; strobes last one clk since ticks are >=4 clk apart
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fifo_wr  <= 1'b0;
      r_fifo_rd  <= 1'b0;
      r_fifo_din <= 1'b0;
      r_rd_dly   <= 1'b0;
    end else begin
      r_fifo_wr  <= w_wr_nxt;
      r_fifo_rd  <= w_rd_nxt;
      r_fifo_din <= w_din_nxt;
      r_rd_dly   <= r_fifo_rd;
    end
  end

  // Amp drive: pwm captures read data the clk after it becomes valid, muted outside streaming/drain
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_amp_pwm <= 1'b0;
      r_amp_sd  <= 1'b0;
    end else begin
      r_amp_sd <= (w_state_nxt != S_IDLE);
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_FILL)) begin
        r_amp_pwm <= 1'b0;
      end else if (r_rd_dly) begin
        r_amp_pwm <= i_fifo_dout;
      end
    end
  end

  // Saturating overrun/underrun event counters
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_overrun_cnt  <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_ovr_inc && (r_overrun_cnt != CNT_MAX)) begin
        r_overrun_cnt <= r_overrun_cnt + CNT_ONE;
      end
      if (w_und_inc && (r_underrun_cnt != CNT_MAX)) begin
        r_underrun_cnt <= r_underrun_cnt + CNT_ONE;
      end
    end
  end

  assign o_mclk         = r_mclk;
  assign o_fifo_din     = r_fifo_din;
  assign o_fifo_wr      = r_fifo_wr;
  assign o_fifo_rd      = r_fifo_rd;
  assign o_amp_pwm      = r_amp_pwm;
  assign o_amp_sd       = r_amp_sd;
  assign o_state        = r_state;
  assign o_overrun_cnt  = r_overrun_cnt;
  assign o_underrun_cnt = r_underrun_cnt;

endmodule
